// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register addresses, exception type codes, ExcCode values,
// reset values and the MTC0-writable mask of Cause.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_RI        = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam logic [4:0] EXCCODE_RI  = 5'd10;
  localparam logic [4:0] EXCCODE_OV  = 5'd12;
  localparam logic [4:0] EXCCODE_TR  = 5'd13;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RESET = 32'h0000_8000;
  localparam logic [31:0] PRID_VALUE   = 32'h004C_0102;
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_dec_t;

  // Maps an exception type to its ExcCode; ERET and unknown codes are not "valid".
  function automatic exc_dec_t decode_exc(input logic [31:0] exc_type);
    exc_dec_t d;
    d.valid = 1'b1;
    d.code  = EXCCODE_INT;
    case (exc_type)
      EXC_INTERRUPT: d.code = EXCCODE_INT;
      EXC_SYSCALL:   d.code = EXCCODE_SYS;
      EXC_RI:        d.code = EXCCODE_RI;
      EXC_OVERFLOW:  d.code = EXCCODE_OV;
      EXC_TRAP:      d.code = EXCCODE_TR;
      default:       d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// MTC0/MFC0 access bus between the pipeline (master) and the CP0 register file (slave).
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;

  modport master (output we_i, waddr_i, data_i, raddr_i, input data_o);
  modport slave  (input we_i, waddr_i, data_i, raddr_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: MTC0/MFC0 access, free-running Count/Compare timer,
// interrupt pending sampling, exception entry and ERET bookkeeping.
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  cp0_reg_if.slave    bus,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic        flush;
  logic        wr_en;
  exc_dec_t    exc;
  logic [31:0] cause_base;

  // An excepting instruction is flushed, so its MTC0 must not land.
  assign flush = (excepttype_i != 32'd0);
  assign wr_en = bus.we_i && !flush;
  assign exc   = decode_exc(excepttype_i);

  assign config_o = CONFIG_RESET;
  assign prid_o   = PRID_VALUE;

  assign cause_base = (wr_en && bus.waddr_i == CP0_CAUSE)
                    ? ((cause_o & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK))
                    : cause_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o     <= 32'd0;
      compare_o   <= 32'd0;
      status_o    <= STATUS_RESET;
      cause_o     <= 32'd0;
      epc_o       <= 32'd0;
      timer_int_o <= 1'b0;
    end else begin
      count_o <= count_o + 32'd1;
      cause_o <= {cause_base[31:16], int_i, cause_base[9:0]};
      if (compare_o != 32'd0 && count_o == compare_o)
        timer_int_o <= 1'b1;

      // NOTE: non-blocking assignments later in this block override earlier ones
      // to the same bits, which is how writes take priority over the defaults above.
      if (wr_en) begin
        case (bus.waddr_i)
          CP0_COUNT:   count_o <= bus.data_i;
          CP0_COMPARE: begin
            compare_o   <= bus.data_i;
            timer_int_o <= 1'b0;
          end
          CP0_STATUS:  status_o <= bus.data_i;
          CP0_EPC:     epc_o    <= bus.data_i;
          default: ;
        endcase
      end

      if (exc.valid) begin
        if (!status_o[STATUS_EXL]) begin
          epc_o             <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                 : current_inst_addr_i;
          cause_o[CAUSE_BD] <= is_in_delayslot_i;
        end
        status_o[STATUS_EXL] <= 1'b1;
        cause_o[6:2]         <= exc.code;
      end else if (excepttype_i == EXC_ERET) begin
        status_o[STATUS_EXL] <= 1'b0;
      end
    end
  end

  // NOTE: assigning a default first keeps this combinational block latch-free.
  always_comb begin
    bus.data_o = 32'd0;
    if (!rst) begin
      case (bus.raddr_i)
        CP0_COUNT:   bus.data_o = count_o;
        CP0_COMPARE: bus.data_o = compare_o;
        CP0_STATUS:  bus.data_o = status_o;
        CP0_CAUSE:   bus.data_o = cause_o;
        CP0_EPC:     bus.data_o = epc_o;
        CP0_PRID:    bus.data_o = prid_o;
        CP0_CONFIG:  bus.data_o = config_o;
        default:     bus.data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: a register-array reference model predicts every
// output each cycle; a negedge monitor pops the predictions and compares.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] excepttype;
  logic [31:0] pc;
  logic        ds;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  always #5 clk = ~clk;

  cp0_reg_if bus ();

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .int_i               (int_i),
    .excepttype_i        (excepttype),
    .current_inst_addr_i (pc),
    .is_in_delayslot_i   (ds),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  typedef struct {
    logic [31:0] count, compare, status, cause, epc, cfg, prid, rdata;
    logic        timer;
  } snap_t;

  snap_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m[32];
  logic        m_timer;
  logic        in_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: CP0 as a 32-entry array indexed by register number.
  function automatic void model_reset();
    foreach (m[i]) m[i] = 32'd0;
    m[12]   = 32'h1000_0000;
    m[15]   = 32'h004C_0102;
    m[16]   = 32'h0000_8000;
    m_timer = 1'b0;
  endfunction

  function automatic void model_step(input logic we, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic [5:0] iv,
                                     input logic [31:0] exc, input logic [31:0] pcv,
                                     input logic dsv);
    logic fire, exl, wr;
    fire = (m[11] != 0) && (m[9] == m[11]);
    exl  = m[12][1];
    wr   = we && (exc == 0);
    m[9] = m[9] + 1;
    if (wr) begin
      case (wa)
        9, 11, 12, 14: m[wa] = wd;
        13: begin
          m[13][9:8]   = wd[9:8];
          m[13][23:22] = wd[23:22];
        end
        default: ;
      endcase
    end
    if (wr && wa == 11) m_timer = 1'b0;
    else if (fire)      m_timer = 1'b1;
    m[13][15:10] = iv;
    if (exc inside {32'h1, 32'h8, 32'ha, 32'hc, 32'hd}) begin
      if (!exl) begin
        m[14]     = dsv ? pcv - 4 : pcv;
        m[13][31] = dsv;
      end
      m[12][1]    = 1'b1;
      m[13][6:2]  = (exc == 32'h1) ? 5'd0 : exc[4:0];
    end else if (exc == 32'he) begin
      m[12][1] = 1'b0;
    end
  endfunction

  function automatic snap_t expect_now(input logic [4:0] ra);
    snap_t s;
    s.count = m[9];  s.compare = m[11]; s.status = m[12]; s.cause = m[13];
    s.epc   = m[14]; s.prid    = m[15]; s.cfg    = m[16]; s.timer = m_timer;
    s.rdata = in_reset ? 32'd0 : m[ra];
    return s;
  endfunction

  // Called just after an edge: applies inputs, predicts, waits one edge, updates model.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [5:0] iv,
                       input logic [31:0] exc, input logic [31:0] pcv, input logic dsv);
    bus.we_i = we; bus.waddr_i = wa; bus.data_i = wd; bus.raddr_i = ra;
    int_i = iv; excepttype = exc; pc = pcv; ds = dsv;
    exp_q.push_back(expect_now(ra));
    @(posedge clk);
    #1;
    if (!rst) model_step(we, wa, wd, iv, exc, pcv, dsv);
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, ra, int_i, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("count",   count_o,   s.count);
        check("compare", compare_o, s.compare);
        check("status",  status_o,  s.status);
        check("cause",   cause_o,   s.cause);
        check("epc",     epc_o,     s.epc);
        check("config",  config_o,  s.cfg);
        check("prid",    prid_o,    s.prid);
        check("timer",   {31'd0, timer_int_o}, {31'd0, s.timer});
        check("data_o",  bus.data_o, s.rdata);
      end
    end
  end

  initial begin : stimulus
    logic [4:0]  addrs[8];
    logic [31:0] excs[8];
    logic [31:0] wd;
    logic [4:0]  wa;
    int          k;
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    excs  = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h20};

    rst = 1'b1; in_reset = 1'b1; model_reset();
    bus.we_i = 0; bus.waddr_i = 0; bus.data_i = 0; bus.raddr_i = 5'd15;
    int_i = 0; excepttype = 0; pc = 0; ds = 0;
    @(posedge clk); #1;
    idle(2, 5'd15);
    rst = 1'b0; in_reset = 1'b0;

    idle(5, 5'd9);
    check("reset_idle_count", count_o, 32'd5);
    check("reset_status", status_o, 32'h1000_0000);
    check("reset_prid", prid_o, 32'h004C_0102);
    check("reset_timer", {31'd0, timer_int_o}, 32'd0);

    idle(5, 5'd9);
    drive(1'b1, 5'd11, 32'd20, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    k = 0;
    while (!timer_int_o && k < 40) begin
      idle(1, 5'd9);
      k++;
    end
    check("timer_rise_count", count_o, 32'd21);
    idle(2, 5'd9);
    drive(1'b1, 5'd11, 32'd100, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
    check("timer_clear", {31'd0, timer_int_o}, 32'd0);

    drive(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'b101010, 32'd0, 32'd0, 1'b0);
    idle(1, 5'd13);

    drive(1'b0, 5'd0, 32'd0, 5'd14, int_i, 32'h8, 32'h100, 1'b1);
    check("exc_epc_ds", epc_o, 32'hFC);
    check("exc_bd", {31'd0, cause_o[31]}, 32'd1);
    check("exc_code", {27'd0, cause_o[6:2]}, 32'd8);
    check("exc_exl", {31'd0, status_o[1]}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 5'd14, int_i, 32'h8, 32'h200, 1'b0);
    check("nested_epc", epc_o, 32'hFC);
    drive(1'b0, 5'd0, 32'd0, 5'd12, int_i, 32'he, 32'd0, 1'b0);
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);

    drive(1'b1, 5'd14, 32'h1234, 5'd14, int_i, 32'hc, 32'h40, 1'b0);
    check("flush_epc", epc_o, 32'h40);

    drive(1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, int_i, 32'd0, 32'd0, 1'b0);
    idle(1, 5'd9);
    check("count_wrap", count_o, 32'd0);
    drive(1'b1, 5'd15, 32'hDEAD_BEEF, 5'd15, int_i, 32'd0, 32'd0, 1'b0);
    check("prid_ro", prid_o, 32'h004C_0102);

    idle(3, 5'd9);
    rst = 1'b1; in_reset = 1'b1; model_reset();
    #1;
    check("async_rst_count", count_o, 32'd0);
    idle(2, 5'd12);
    rst = 1'b0; in_reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      wa = addrs[$urandom_range(0, 7)];
      wd = $urandom;
      if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = m[9] + $urandom_range(1, 6);
      drive($urandom_range(0, 1) == 1, wa, wd, 5'($urandom_range(0, 31)),
            6'($urandom), ($urandom_range(0, 9) < 7) ? 32'd0 : excs[$urandom_range(0, 7)],
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
    end
    idle(1, 5'd9);

    k = 0;
    while (exp_q.size() > 0 && k < 5) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
